// File: rtl/blake2_m_schedule.sv
// BLAKE2b message-word scheduler.
// Captures a 1024-bit block and, for each half-round, presents the
// SIGMA-permuted m0/m1 word pairs to the four parallel G instances.
// The consumer steps the schedule with a one-cycle advance strobe.
module blake2_m_schedule #(
  parameter int NUM_ROUNDS = 12
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [1023:0] i_block,
  input  logic          i_advance,
  output logic          o_ready,
  output logic          o_g_valid,
  output logic [3:0]    o_round,
  output logic          o_diag,
  output logic          o_done,
  output logic [63:0]   o_g0_m0,
  output logic [63:0]   o_g0_m1,
  output logic [63:0]   o_g1_m0,
  output logic [63:0]   o_g1_m1,
  output logic [63:0]   o_g2_m0,
  output logic [63:0]   o_g2_m1,
  output logic [63:0]   o_g3_m0,
  output logic [63:0]   o_g3_m1
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  // One SIGMA row packed as 16 nibbles, position 0 in the most significant nibble.
  function automatic logic [63:0] sigma_row(input logic [3:0] row);
    case (row)
      4'd0:    sigma_row = 64'h0123456789ABCDEF;
      4'd1:    sigma_row = 64'hEA489FD61C02B753;
      4'd2:    sigma_row = 64'hB8C052FDAE367194;
      4'd3:    sigma_row = 64'h7931DCBE265A40F8;
      4'd4:    sigma_row = 64'h905724AFE1BC683D;
      4'd5:    sigma_row = 64'h2C6A0B834D75FE19;
      4'd6:    sigma_row = 64'hC51FED4A0763928B;
      4'd7:    sigma_row = 64'hDB7EC13950F4862A;
      4'd8:    sigma_row = 64'h6FE9B308C2D714A5;
      4'd9:    sigma_row = 64'hA2847615FB9E3CD0;
      default: sigma_row = 64'h0123456789ABCDEF;
    endcase
  endfunction

  // Message-word index found at a given position of a packed SIGMA row.
  function automatic logic [3:0] pick(input logic [63:0] perm, input logic [3:0] pos);
    logic [5:0] sh;
    sh   = {4'd15 - pos, 2'b00};
    pick = perm[sh +: 4];
  endfunction

  logic [63:0] r_m [16];
  logic [1:0]  r_state;
  logic [3:0]  r_round;
  logic        r_diag;
  logic        r_ready;
  logic        r_g_valid;
  logic        r_done;

  logic [1:0]  w_state_nxt;
  logic [3:0]  w_round_nxt;
  logic        w_diag_nxt;
  logic        w_capture;
  logic [3:0]  w_row;
  logic [63:0] w_perm;

  // Rounds 10 and up reuse the first SIGMA rows.
  always_comb begin
    if (r_round >= 4'd10) begin
      w_row = r_round - 4'd10;
    end else begin
      w_row = r_round;
    end
    w_perm = sigma_row(w_row);
  end

  // Position within the row is {diag, G index, m0/m1}.
  assign o_g0_m0 = r_m[pick(w_perm, {r_diag, 2'd0, 1'b0})];
  assign o_g0_m1 = r_m[pick(w_perm, {r_diag, 2'd0, 1'b1})];
  assign o_g1_m0 = r_m[pick(w_perm, {r_diag, 2'd1, 1'b0})];
  assign o_g1_m1 = r_m[pick(w_perm, {r_diag, 2'd1, 1'b1})];
  assign o_g2_m0 = r_m[pick(w_perm, {r_diag, 2'd2, 1'b0})];
  assign o_g2_m1 = r_m[pick(w_perm, {r_diag, 2'd2, 1'b1})];
  assign o_g3_m0 = r_m[pick(w_perm, {r_diag, 2'd3, 1'b0})];
  assign o_g3_m1 = r_m[pick(w_perm, {r_diag, 2'd3, 1'b1})];

  assign o_ready   = r_ready;
  assign o_g_valid = r_g_valid;
  assign o_done    = r_done;
  assign o_round   = r_round;
  assign o_diag    = r_diag;

  // Next-state logic: capture on start in IDLE, step half-rounds on advance in ACTIVE.
  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_diag_nxt  = r_diag;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_capture   = 1'b1;
          w_state_nxt = S_ACTIVE;
          w_round_nxt = 4'd0;
          w_diag_nxt  = 1'b0;
        end else begin
          w_capture   = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (!i_advance) begin
          w_state_nxt = S_ACTIVE;
        end else if (!r_diag) begin
          w_diag_nxt  = 1'b1;
        end else if (r_round != LAST_ROUND) begin
          w_diag_nxt  = 1'b0;
          w_round_nxt = r_round + 4'd1;
        end else begin
          w_state_nxt = S_FINISH;
          w_diag_nxt  = 1'b0;
          w_round_nxt = 4'd0;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_round_nxt = 4'd0;
        w_diag_nxt  = 1'b0;
      end
    endcase
  end

  // Control state and registered status flags decoded from the next state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_round   <= 4'd0;
      r_diag    <= 1'b0;
      r_ready   <= 1'b1;
      r_g_valid <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_round   <= w_round_nxt;
      r_diag    <= w_diag_nxt;
      r_ready   <= (w_state_nxt == S_IDLE);
      r_g_valid <= (w_state_nxt == S_ACTIVE);
      r_done    <= (w_state_nxt == S_FINISH);
    end
  end

  // Message word array: cleared on reset, loaded on an accepted start, otherwise held.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 16; i++) begin
        r_m[i] <= 64'd0;
      end
    end else if (w_capture) begin
      for (int i = 0; i < 16; i++) begin
        r_m[i] <= i_block[64*i +: 64];
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        r_m[i] <= r_m[i];
      end
    end
  end

endmodule

// File: tb/tb_blake2_m_schedule.sv
// Self-checking bench for blake2_m_schedule: directed scenarios plus a
// randomized phase, all checked every cycle against a half-round-counter model.
module tb_blake2_m_schedule;

  localparam int NR = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          advance = 1'b0;
  logic [1023:0] block = '0;
  logic          ready, g_valid, diag, done;
  logic [3:0]    round;
  logic [63:0]   g0_m0, g0_m1, g1_m0, g1_m1, g2_m0, g2_m1, g3_m0, g3_m1;
  logic [63:0]   dut_w [8];

  blake2_m_schedule #(.NUM_ROUNDS(NR)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_block(block), .i_advance(advance),
    .o_ready(ready), .o_g_valid(g_valid), .o_round(round), .o_diag(diag), .o_done(done),
    .o_g0_m0(g0_m0), .o_g0_m1(g0_m1), .o_g1_m0(g1_m0), .o_g1_m1(g1_m1),
    .o_g2_m0(g2_m0), .o_g2_m1(g2_m1), .o_g3_m0(g3_m0), .o_g3_m1(g3_m1)
  );

  assign dut_w[0] = g0_m0; assign dut_w[1] = g0_m1;
  assign dut_w[2] = g1_m0; assign dut_w[3] = g1_m1;
  assign dut_w[4] = g2_m0; assign dut_w[5] = g2_m1;
  assign dut_w[6] = g3_m0; assign dut_w[7] = g3_m1;

  always #5 clk = ~clk;

  int sig [10][16] = '{
    '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
    '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
    '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
    '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
    '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
    '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
    '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
    '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
    '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
    '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
  };

  // Model: mode 0 idle, 1 active, 2 finish; k = half-rounds consumed so far.
  int          md_mode = 0;
  int          md_k = 0;
  logic [63:0] md_m [16];

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      md_mode = 0;
      md_k = 0;
      for (int i = 0; i < 16; i++) md_m[i] = 64'd0;
    end else if (md_mode == 0) begin
      if (start) begin
        for (int i = 0; i < 16; i++) md_m[i] = block[64*i +: 64];
        md_mode = 1;
        md_k = 0;
      end
    end else if (md_mode == 1) begin
      if (advance) begin
        if (md_k == 2*NR - 1) begin
          md_mode = 2;
          md_k = 0;
        end else begin
          md_k++;
        end
      end
    end else begin
      md_mode = 0;
    end
  endtask

  task automatic check_all();
    int r, d;
    r = md_k / 2;
    d = md_k % 2;
    cmp("ready", 64'(ready), 64'(md_mode == 0));
    cmp("g_valid", 64'(g_valid), 64'(md_mode == 1));
    cmp("done", 64'(done), 64'(md_mode == 2));
    cmp("round", 64'(round), 64'(r));
    cmp("diag", 64'(diag), 64'(d));
    for (int j = 0; j < 8; j++)
      cmp($sformatf("g%0d_m%0d", j / 2, j % 2), dut_w[j], md_m[sig[r % 10][d*8 + j]]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (done) done_seen++;
    check_all();
  endtask

  // Literal check of the eight words when m[i]=i: each nibble of e is a word value.
  task automatic lit(input string nm, input logic [31:0] e);
    for (int j = 0; j < 8; j++)
      cmp($sformatf("%s[%0d]", nm, j), dut_w[j], 64'(e[4*(7-j) +: 4]));
  endtask

  task automatic set_block(input int base);
    for (int i = 0; i < 16; i++) block[64*i +: 64] = 64'(base + i);
  endtask

  task automatic run_to_done(input string nm);
    int c;
    c = 0;
    advance = 1'b1;
    while (!done && c < 100) begin
      tick();
      c++;
    end
    cmp({nm, "_done_reached"}, 64'(done), 64'd1);
    advance = 1'b0;
  endtask

  initial begin
    int dn, vcnt, r10;
    for (int i = 0; i < 16; i++) md_m[i] = 64'd0;
    tick(); tick();
    reset = 1'b0;
    tick();
    cmp("rst_ready", 64'(ready), 64'd1);
    cmp("rst_valid", 64'(g_valid), 64'd0);
    cmp("rst_word", g2_m1, 64'd0);

    // Tests 1/2: m[i]=i, step through round 0 and round 1.
    set_block(0);
    start = 1'b1; tick(); start = 1'b0;
    cmp("t1_valid", 64'(g_valid), 64'd1);
    lit("t1_r0c", 32'h01234567);
    advance = 1'b1; tick(); advance = 1'b0;
    cmp("t1_diag", 64'(diag), 64'd1);
    lit("t1_r0d", 32'h89ABCDEF);
    advance = 1'b1; tick(); advance = 1'b0;
    cmp("t2_round", 64'(round), 64'd1);
    lit("t2_r1c", 32'hEA489FD6);
    advance = 1'b1; tick(); advance = 1'b0;
    lit("t2_r1d", 32'h1C02B753);

    // Test 4: start ignored at round 3 diagonal.
    advance = 1'b1;
    repeat (4) tick();
    advance = 1'b0;
    cmp("t4_round", 64'(round), 64'd3);
    cmp("t4_diag", 64'(diag), 64'd1);
    set_block(32'hFF00);
    start = 1'b1; tick(); start = 1'b0;
    lit("t4_r3d", 32'h265A40F8);
    tick();
    lit("t4_r3d_hold", 32'h265A40F8);
    run_to_done("t4");
    tick();

    // Test 3: start with advance, advance held high through the block.
    set_block(0);
    dn = done_seen;
    start = 1'b1; advance = 1'b1; tick(); start = 1'b0;
    cmp("t3_first_round", 64'(round), 64'd0);
    cmp("t3_first_diag", 64'(diag), 64'd0);
    vcnt = 0; r10 = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (g_valid) vcnt++;
      if (g_valid && round == 4'd10 && !diag) begin
        r10++;
        lit("t3_r10c", 32'h01234567);
      end
      tick();
    end
    cmp("t3_done", 64'(done), 64'd1);
    cmp("t3_valid_cycles", 64'(vcnt), 64'd24);
    cmp("t3_r10_seen", 64'(r10), 64'd1);
    cmp("t3_valid_in_done", 64'(g_valid), 64'd0);
    advance = 1'b0;
    tick();
    cmp("t3_ready_after", 64'(ready), 64'd1);
    cmp("t3_done_pulses", 64'(done_seen - dn), 64'd1);

    // Test 5: reset mid-block, then advance while idle.
    start = 1'b1; tick(); start = 1'b0;
    advance = 1'b1; repeat (10) tick(); advance = 1'b0;
    cmp("t5_round", 64'(round), 64'd5);
    dn = done_seen;
    reset = 1'b1; tick(); reset = 1'b0;
    cmp("t5_ready", 64'(ready), 64'd1);
    cmp("t5_valid", 64'(g_valid), 64'd0);
    cmp("t5_round0", 64'(round), 64'd0);
    for (int j = 0; j < 8; j++) cmp($sformatf("t5_zero[%0d]", j), dut_w[j], 64'd0);
    advance = 1'b1; repeat (3) tick(); advance = 1'b0;
    cmp("t5_idle_ready", 64'(ready), 64'd1);
    cmp("t5_no_done", 64'(done_seen - dn), 64'd0);

    // Reset together with start: reset wins.
    set_block(32'h55);
    reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
    cmp("rs_ready", 64'(ready), 64'd1);
    cmp("rs_word", g0_m0, 64'd0);

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 32; i++) block[32*i +: 32] = $urandom;
      start   = ($urandom_range(0, 7) == 0);
      advance = ($urandom_range(0, 1) == 1);
      reset   = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset = 1'b0; start = 1'b0; advance = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/blake2_m_schedule.md
Name: blake2_m_schedule

Overview:
- Message-word scheduler that sits directly upstream of the four parallel G-function instances in the BLAKE2b compression core.
- Captures one 1024-bit message block and steps through NUM_ROUNDS rounds, each split into a column half-round and a diagonal half-round.
- For each half-round it presents the SIGMA-permuted m0/m1 word pair to each of the four G instances.
- The downstream round logic consumes the words and returns a one-cycle advance strobe per half-round.

Parameters:
NUM_ROUNDS, 12, number of full rounds per block; legal range 1..16.

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
start  input  1  capture block and begin schedule; honoured only while ready=1
block  input  1024  message block; word m[i] = block[64*i +: 64], i=0..15
advance  input  1  consumer done with current half-round; honoured only while g_valid=1
ready  output  1  idle, able to accept start
g_valid  output  1  G word outputs valid for current half-round
round  output  4  current round index, 0..NUM_ROUNDS-1
diag  output  1  0 = column half-round, 1 = diagonal half-round
done  output  1  one-cycle pulse after the final half-round is consumed
g0_m0, g0_m1, g1_m0, g1_m1, g2_m0, g2_m1, g3_m0, g3_m1  output  64 each  message words for G instances 0..3

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset); it is sampled only on a clk rising edge.
- Registered state: the 16x64-bit message word array, FSM state, round, and diag.
- Reset values: ready=1, g_valid=0, done=0, round=0, diag=0, all message words=0, and therefore all g*_m* outputs=0.
- FSM states:
  - IDLE: ready=1, g_valid=0.
  - ACTIVE: ready=0, g_valid=1.
  - FINISH: ready=0, g_valid=0, done=1; lasts exactly one cycle.
- IDLE -> ACTIVE: on start=1 at edge T, all 16 words are captured from block, round=0, diag=0. At T+1: g_valid=1 and round-0 column words are on the outputs. Start-to-valid latency is one cycle.
- g*_m* outputs are combinational from the registered words, round, and diag. They are stable for the whole time g_valid=1 within a half-round.
- SIGMA selection:
  - s = SIGMA[round mod 10], the standard BLAKE2 permutation table (RFC 7693 section 2.7).
  - diag=0: gi_m0 = m[s[2i]], gi_m1 = m[s[2i+1]], for i=0..3.
  - diag=1: gi_m0 = m[s[8+2i]], gi_m1 = m[s[9+2i]].
  - Rounds 10 and 11 therefore reuse SIGMA rows 0 and 1.
- ACTIVE with advance=1:
  - If diag=0: set diag=1.
  - Else if round < NUM_ROUNDS-1: set diag=0 and round=round+1.
  - Else: go to FINISH, with diag=0 and round=0.
- advance held high continuously steps one half-round per cycle, with no bubbles.
- FINISH -> IDLE unconditionally on the next edge; done drops and ready rises in the same cycle.
- The message word array keeps its contents after FINISH until the next start or reset.
- start while ready=0 (ACTIVE or FINISH): ignored, with no effect on block capture or sequence.
- advance while g_valid=0 (IDLE or FINISH): ignored.
- start and advance together in IDLE: start is taken and advance is ignored; the first half-round is never skipped.
- Reset during ACTIVE or FINISH: on the reset edge, return to IDLE with all reset values, including clearing the message words. No done pulse is produced.
- Reset together with start: reset wins.
- Total schedule: exactly 2*NUM_ROUNDS honoured advance strobes per block. With NUM_ROUNDS=12 that is 24.

Test Plan:
1. Reset, then block with m[i]=i, start at cycle 0. Required:
   - Cycle 1: g_valid=1, round=0, diag=0; G0..G3 pairs = (0,1),(2,3),(4,5),(6,7).
   - After one advance: diag=1; pairs = (8,9),(10,11),(12,13),(14,15).
2. Same block, second advance. Required: round=1, diag=0; pairs = (14,10),(4,8),(9,15),(13,6). After the next advance: diag=1; pairs = (1,12),(0,2),(11,7),(5,3).
3. advance held high from cycle 1. Required:
   - g_valid=1 for exactly 24 cycles.
   - round 10 column words equal round 0 column words: (0,1),(2,3),(4,5),(6,7).
   - done=1 for exactly one cycle after the 24th advance, with g_valid=0 in that cycle.
   - ready=1 on the following cycle.
4. start pulsed with a different block (m[i]=0xFF00+i) at round 3, diag=1. Required: outputs and sequence unchanged, words still m[i]=i. start together with advance in IDLE: cycle 1 shows round 0, diag 0.
5. reset asserted at round 5, diag 0. Required: next cycle ready=1, g_valid=0, round=0, all g*_m*=0, no done pulse. advance pulsed while idle: no state change.
